// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared types for the ID-stage stall/flush controller
package pipeline_stall_controller_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_r;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when the ID instruction reads a register this in-flight entry will write.
    function automatic logic entry_match(
        input sb_entry_t        e,
        input logic [REG_W-1:0] src1,
        input logic             rn_valid,
        input logic [REG_W-1:0] src2,
        input logic             two_src
    );
        return e.valid && e.wb_en &&
               ((rn_valid && (src1 == e.dest)) || (two_src && (src2 == e.dest)));
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_stall_scoreboard.sv
// rtl/pipeline_stall_controller_stall_scoreboard.sv - EXE/MEM destination tracker and RAW hazard detect
module stall_scoreboard
    import pipeline_stall_controller_pkg::*;
#(
    parameter int TRACK_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic             rn_valid,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             fwd_en,
    input  logic             flush,
    input  logic             freeze_pipe,
    output logic             hazard
);

    sb_entry_t              stage_q [TRACK_DEPTH];
    logic [TRACK_DEPTH-1:0] match;
    sb_entry_t              issue;

    always_comb begin
        match = '0;
        for (int i = 0; i < TRACK_DEPTH; i++) begin
            match[i] = entry_match(stage_q[i], src1, rn_valid, src2, two_src);
        end
    end

    // With forwarding only a load still in EXE cannot supply its result in time.
    always_comb begin
        hazard = 1'b0;
        if (!flush) begin
            if (fwd_en) hazard = match[0] && stage_q[0].mem_r;
            else        hazard = |match;
        end
    end

    always_comb begin
        issue = SB_BUBBLE;
        if (!hazard && !flush) begin
            issue.valid = id_wb_en;
            issue.dest  = id_dest;
            issue.wb_en = id_wb_en;
            issue.mem_r = id_mem_r_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TRACK_DEPTH; i++) stage_q[i] <= SB_BUBBLE;
        end else if (!freeze_pipe) begin
            stage_q[0] <= issue;
            for (int i = 1; i < TRACK_DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - decode-side pipeline sequencer: hazard stall, branch flush, memory freeze
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int TRACK_DEPTH = 2,
    parameter int FLUSH_LEN   = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             Two_src,
    input  logic             is_Rn_valid,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hazard,
    output logic             freeze_if,
    output logic             flush,
    output logic             freeze_pipe,
    output logic             mem_err,
    output logic [15:0]      stall_cnt
);

    localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_LEN - 1);
    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [15:0] stall_cnt_q;

    assign freeze_pipe = mem_req & ~mem_ready;
    assign flush       = (state_q == ST_FLUSH);
    assign freeze_if   = hazard | freeze_pipe;
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;

    stall_scoreboard #(
        .TRACK_DEPTH (TRACK_DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .src1        (src1),
        .src2        (src2),
        .two_src     (Two_src),
        .rn_valid    (is_Rn_valid),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .fwd_en      (fwd_en),
        .flush       (flush),
        .freeze_pipe (freeze_pipe),
        .hazard      (hazard)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        case (state_q)
            ST_RUN: begin
                // A frozen EXE holds the branch, so it is picked up again on release.
                if (freeze_pipe) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else if (branch_taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) state_d = ST_RUN;
                else                   flush_cnt_d = flush_cnt_q - 2'd1;
            end
            ST_MEM_WAIT: begin
                if (!freeze_pipe) begin
                    wait_cnt_d = '0;
                    if (branch_taken) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    if (wait_cnt_q != 4'hF) wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) mem_err_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            if (freeze_if && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - table-driven scoreboard bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1, src2, id_dest;
    logic        Two_src, is_Rn_valid, id_wb_en, id_mem_r_en, fwd_en;
    logic        branch_taken, mem_req, mem_ready;
    logic        hazard, freeze_if, flush, freeze_pipe, mem_err;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .TRACK_DEPTH (2),
        .FLUSH_LEN   (1),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .Two_src      (Two_src),
        .is_Rn_valid  (is_Rn_valid),
        .id_dest      (id_dest),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .fwd_en       (fwd_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hazard       (hazard),
        .freeze_if    (freeze_if),
        .flush        (flush),
        .freeze_pipe  (freeze_pipe),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    // exp = {hazard, freeze_if, flush, freeze_pipe, mem_err}
    typedef struct {
        string      name;
        logic [3:0] s1;
        logic       rn;
        logic [3:0] s2;
        logic       two;
        logic [3:0] dest;
        logic       wb;
        logic       mr;
        logic       fwd;
        logic       br;
        logic       mreq;
        logic       mrdy;
        logic [4:0] exp;
    } vec_t;

    vec_t        tbl[$];
    vec_t        exp_q[$];
    logic [15:0] stall_q[$];
    logic [15:0] model_stall = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic vec_t mk(input string name, input logic [3:0] s1, input logic rn,
                                input logic [3:0] s2, input logic two, input logic [3:0] dest,
                                input logic wb, input logic mr, input logic fwd, input logic br,
                                input logic mreq, input logic mrdy, input logic [4:0] exp);
        vec_t v;
        v.name = name; v.s1 = s1; v.rn = rn; v.s2 = s2; v.two = two; v.dest = dest;
        v.wb = wb; v.mr = mr; v.fwd = fwd; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        src1 = v.s1; is_Rn_valid = v.rn; src2 = v.s2; Two_src = v.two;
        id_dest = v.dest; id_wb_en = v.wb; id_mem_r_en = v.mr; fwd_en = v.fwd;
        branch_taken = v.br; mem_req = v.mreq; mem_ready = v.mrdy;
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check_out();
        vec_t        e;
        logic [15:0] es;
        e  = exp_q.pop_front();
        es = stall_q.pop_front();
        n_cmp++;
        if ({hazard, freeze_if, flush, freeze_pipe, mem_err} !== e.exp) begin
            n_bad++;
            $display("FAIL %s {hz,fi,fl,fp,me} got %b want %b", e.name,
                     {hazard, freeze_if, flush, freeze_pipe, mem_err}, e.exp);
        end
        check_val({e.name, "_stall_cnt"}, stall_cnt, es);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        stall_q.push_back(model_stall);
        #2;
        check_out();
        if (v.exp[3] && model_stall != 16'hFFFF) model_stall = model_stall + 16'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        #12;
        check_val("reset_outputs", {11'd0, hazard, freeze_if, flush, freeze_pipe, mem_err}, 16'd0);
        check_val("reset_stall_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        //              name              s1 rn s2 tw  d wb mr fw br mq mr  exp
        tbl.push_back(mk("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("add_r1",          0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("raw_exe",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(mk("raw_mem",         1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(mk("raw_clear",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("ldr_r2",          0, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("load_use",        0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 5'b11000));
        tbl.push_back(mk("load_use_done",   0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("add_r2",          0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("alu_fwd",         0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("mov_r3",          0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("mov_no_rn",       3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("imm_no_rm",       0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("mov_r15",         0, 0, 0, 0, 15, 1, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("raw_r15_exe",    15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(mk("raw_r15_mem",    15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000));
        tbl.push_back(mk("raw_r15_clear",  15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        tbl.push_back(mk("branch",          0, 0, 0, 0, 4, 1, 0, 0, 1, 0, 0, 5'b00000));
        tbl.push_back(mk("flush_kill",      4, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0, 5'b00100));
        tbl.push_back(mk("post_flush",      5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));

        foreach (tbl[i]) apply(tbl[i]);

        // Long memory wait with a pending branch and a held load-use hazard.
        apply(mk("ldr_r6", 0, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 5'b00000));
        for (int i = 0; i < 20; i++) begin
            apply(mk($sformatf("mem_wait_%0d", i), 6, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0,
                     {4'b1101, (i >= 16) ? 1'b1 : 1'b0}));
        end
        apply(mk("mem_release",     6, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 5'b11001));
        apply(mk("flush_after_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101));
        apply(mk("idle_sticky_err", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001));

        // Asynchronous reset in the middle of a memory wait.
        apply(mk("add_r7", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 5'b00001));
        for (int i = 0; i < 5; i++) begin
            apply(mk($sformatf("wait_pre_rst_%0d", i), 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b11011));
        end
        #1;
        rst = 1'b0;
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        #1;
        check_val("async_rst_mem_err", {15'd0, mem_err}, 16'd0);
        check_val("async_rst_flush", {15'd0, flush}, 16'd0);
        check_val("async_rst_stall_cnt", stall_cnt, 16'd0);
        check_val("async_rst_outputs", {11'd0, hazard, freeze_if, flush, freeze_pipe, mem_err}, 16'd0);
        model_stall = '0;
        @(negedge clk);
        rst = 1'b1;
        apply(mk("sb_cleared", 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
        apply(mk("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
